// File: rtl/inv_addkey_mixcol_stage.sv
// Decryption round stage: AddRoundKey followed by InvMixColumns (skipped on the
// final round), registered behind a valid/ready handshake with an optional
// two-entry skid buffer. Tag and last flag travel with their state word.
module inv_addkey_mixcol_stage #(
  parameter int TAG_W = 4,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last
);

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one 32-bit column; a0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Apply InvMixColumns to all four columns of the state.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    inv_mix_columns = r;
  endfunction

  logic [127:0]     result_p0;
  logic [127:0]     addkey_p0;
  logic             skid_vld_p1;
  logic [127:0]     skid_state_p1;
  logic [TAG_W-1:0] skid_tag_p1;
  logic             skid_last_p1;

  logic accept;
  logic drain;
  logic out_open;
  logic load_out_skid;
  logic load_out_in;
  logic load_skid;

  // Stage p0: combinational round function on the input side.
  always_comb begin
    addkey_p0 = in_state ^ in_key;
    result_p0 = in_last ? addkey_p0 : inv_mix_columns(addkey_p0);
  end

  assign in_ready = (SKID != 0) ? !skid_vld_p1 : (!out_valid || out_ready);

  // Handshake decode: where the accepted word and the skid word go this cycle.
  always_comb begin
    accept        = in_valid && in_ready && !flush;
    drain         = out_valid && out_ready;
    out_open      = !out_valid || drain;
    load_out_skid = skid_vld_p1 && out_open && !flush;
    load_out_in   = accept && out_open && !skid_vld_p1;
    load_skid     = (SKID != 0) && accept && (!out_open || skid_vld_p1);
  end

  // Stage p1: occupancy of the output register and the skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (out_open) begin
      out_valid   <= skid_vld_p1 || accept;
      skid_vld_p1 <= skid_vld_p1 && accept;
    end else begin
      skid_vld_p1 <= skid_vld_p1 || load_skid;
    end
  end

  // Output data register; cleared on reset so no stale word is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= '0;
      out_tag   <= '0;
      out_last  <= 1'b0;
    end else if (load_out_skid) begin
      out_state <= skid_state_p1;
      out_tag   <= skid_tag_p1;
      out_last  <= skid_last_p1;
    end else if (load_out_in) begin
      out_state <= result_p0;
      out_tag   <= in_tag;
      out_last  <= in_last;
    end
  end

  // Skid data register; contents only matter while skid_vld_p1 is set.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_state_p1 <= result_p0;
      skid_tag_p1   <= in_tag;
      skid_last_p1  <= in_last;
    end
  end

endmodule

// File: tb/tb_inv_addkey_mixcol_stage.sv
// Bench for inv_addkey_mixcol_stage (SKID=1): directed vectors plus random
// traffic compared every cycle against a queue-based reference model.
module tb_inv_addkey_mixcol_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic [3:0]   out_tag;
  logic         out_last;

  int errors = 0;
  int checks = 0;

  // Model entries: {last, tag, state}
  logic [132:0] q[$];

  inv_addkey_mixcol_stage #(.TAG_W(4), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_tag(out_tag), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Reference round function: matrix form of InvMixColumns over the state.
  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0]   coef [4];
    logic [7:0]   a, acc;
    logic [127:0] t, r;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    t = s ^ k;
    if (last) return t;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          a = t[127 - 8*(4*c + j) -: 8];
          acc ^= gf_mul(coef[(j - row + 4) % 4], a);
        end
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    return r;
  endfunction

  always @(negedge rst_n) q.delete();

  // Compare process: DUT outputs vs model every cycle, then advance the model.
  always @(negedge clk) begin
    logic         exp_valid;
    logic         exp_ready;
    logic [132:0] h;
    if (!rst_n) begin
      chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_out_state", out_state, 128'd0);
      q.delete();
    end else begin
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() < 2);
      chk("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
      chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
      if (exp_valid) begin
        h = q[0];
        chk("out_state", out_state, h[127:0]);
        chk("out_tag", {124'd0, out_tag}, {124'd0, h[131:128]});
        chk("out_last", {127'd0, out_last}, {127'd0, h[132]});
      end
      if (flush) q.delete();
      else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready)
          q.push_back({in_last, in_tag, model(in_state, in_key, in_last)});
      end
    end
  end

  // Present one input and hold it until accepted; returns cycles taken.
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic last,
                      input logic [3:0] tg, output int cyc);
    bit done = 0;
    cyc = 0;
    in_valid = 1'b1; in_state = s; in_key = k; in_last = last; in_tag = tg;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc > 50) begin
        chk("send_timeout", 128'd1, 128'd0);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  int n, total;

  initial begin
    // Pin the model with hand-computed vectors.
    chk("model_mix", model(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0),
        128'hdb135345_f20a225c_01010101_c6c6c6c6);
    chk("model_last", model(128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b1),
        128'hffeeddcc_bbaa9988_77665544_33221100);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_tag", {124'd0, out_tag}, 128'd0);
    chk("reset_out_last", {127'd0, out_last}, 128'd0);
    @(posedge clk); #1;

    // Non-final round
    out_ready = 1'b1;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0, 4'h5, n);
    chk("nonfinal_valid", {127'd0, out_valid}, 128'd1);
    chk("nonfinal_state", out_state, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    @(posedge clk); #1;

    // Final round
    send(128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b1, 4'h6, n);
    chk("final_state", out_state, 128'hffeeddcc_bbaa9988_77665544_33221100);
    chk("final_last", {127'd0, out_last}, 128'd1);
    @(posedge clk); #1;

    // Backpressure: tags 1,2 held, tag 3 waits, then ordered drain
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd1, n);
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd2, n);
    chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    fork
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd3, n);
      begin
        repeat (3) @(posedge clk); #1;
        chk("bp_hold_tag", {124'd0, out_tag}, 128'd1);
        chk("bp_still_blocked", {127'd0, in_ready}, 128'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
          @(negedge clk);
          chk("bp_order_valid", {127'd0, out_valid}, 128'd1);
          chk("bp_order_tag", {124'd0, out_tag}, i);
        end
      end
    join
    repeat (2) @(posedge clk); #1;

    // Full throughput: 16 back-to-back inputs, one cycle each
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom), 4'(i), n);
      total += n;
    end
    chk("throughput_cycles", total, 128'd16);
    repeat (2) @(posedge clk); #1;

    // Flush with two entries held and an input offered in the flush cycle
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0, 4'hA, n);
    send({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0, 4'hB, n);
    in_valid = 1'b1; in_tag = 4'hC; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Async reset while a result is held
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0, 4'h7, n);
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {127'd0, out_valid}, 128'd0);
    chk("async_out_state", out_state, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("async_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      in_last   = 1'($urandom);
      in_tag    = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_addkey_mixcol_stage.md
Name: inv_addkey_mixcol_stage

Overview:
- Decryption datapath stage directly downstream of the inverse S-box substitution stage, which produces the 128-bit substituted state.
- Each cycle it XORs the substituted state with the current round key (AddRoundKey). For every round except the final one, it then applies InvMixColumns.
- The result is registered behind a valid/ready handshake with a skid buffer, so backpressure never drops data.
- Output feeds the next round's InvShiftRows or, on the final round, the plaintext register.

Parameters:
- TAG_W, 4, width of the sideband tag (round index / block id) carried alongside the state, unmodified.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all held entries.
- in_valid  in  1  input state/key valid.
- in_ready  out  1  stage can accept this cycle.
- in_state  in  128  substituted state; [127:120] = byte 0 (row 0, col 0); column-major per FIPS-197.
- in_key  in  128  round key, same byte order.
- in_last  in  1  final round: skip InvMixColumns.
- in_tag  in  TAG_W  sideband, passed through.
- out_valid  out  1  output holds a result.
- out_ready  in  1  consumer accepts.
- out_state  out  128  result.
- out_tag  out  TAG_W  tag of the result.
- out_last  out  1  in_last of the result.

Behaviour:
- Async reset (rst_n low): out_valid=0, skid empty, out_state=0, out_tag=0, out_last=0, in_ready=1 once rst_n is high.
- Function: t = in_state ^ in_key; result = in_last ? t : InvMixColumns(t). Computed combinationally on the input side.
- InvMixColumns per column (a0..a3 = bytes 4c..4c+3):
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3; the other rows rotate the coefficients.
  - GF(2^8) with modulus 0x11b, built from xtime chains, no lookup tables.
- Latency: 1 cycle. A result accepted at edge N is visible on out_* after edge N.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
  - in_valid may drop without a transfer.
- SKID=1:
  - in_ready = !skid_valid, a registered value.
  - On an accept, the result loads the output register if it is empty or draining this cycle. Otherwise it loads the skid register.
  - When the output drains and the skid is full, the skid moves to the output the same cycle.
  - If an accept happens in that same cycle, it loads the skid.
  - Strict FIFO order; maximum two entries held.
- SKID=0: in_ready = !out_valid || out_ready. One entry held.
- Simultaneous accept and drain at full throughput: one result per cycle, no bubbles.
- flush=1: at the next edge out_valid=0 and the skid is emptied. Any input accepted in the flush cycle is discarded. Data registers need not clear.
- Reset mid-operation: all in-flight entries are lost; no partial output appears.
- Tag and last flag travel with their state word; they are never mixed across entries.

Test Plan:
- Non-final round:
  - Stimulus: in_key=0, in_last=0, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Response: one cycle later out_valid=1, out_state=db135345_f20a225c_01010101_c6c6c6c6.
- Final round:
  - Stimulus: in_last=1, in_key=all-ones, in_state=00112233_44556677_8899aabb_ccddeeff.
  - Response: out_state=ffeeddcc_bbaa9988_77665544_33221100, out_last=1.
- Backpressure (SKID=1):
  - Stimulus: out_ready=0; stream tags 1,2,3 with in_valid continuously high.
  - Response: tags 1 and 2 are accepted; in_ready=0 from the cycle after tag 2 is accepted; tag 3 is held.
  - Then raise out_ready: outputs appear in order 1,2,3 on consecutive cycles, no loss or duplication.
- Full throughput:
  - Stimulus: 16 back-to-back inputs with out_ready=1.
  - Response: 16 consecutive out_valid cycles, in_ready never low, each result matching the reference model.
- Flush:
  - Stimulus: hold two entries (out_ready=0), assert flush for one cycle while in_valid=1.
  - Response: out_valid=0 and in_ready=1 next cycle; the flushed-cycle input never appears.
- Async reset:
  - Stimulus: drop rst_n mid-clock while out_valid=1.
  - Response: out_valid=0 and out_state=0 immediately, before the next edge.
